alu_arbiter: RTL
================

# alu_arbiter

Shares the single 64-bit ALU between two independent requesters: the execute-stage datapath (port 0) and the address-generation/auxiliary unit (port 1). Each requester submits an operand pair and a 4-bit ALU control code over a valid/ready handshake. The block grants one request at a time with round-robin fairness and drives the registered operands onto the ALU. It captures BusW/Zero and returns them on the granted requester's response channel, held until that requester accepts.

## Interface
- `W`, default 64: operand/result width.
- `CLK` input 1: clock; all state updates on rising edge.
- `Reset` input 1: synchronous, active-high reset.
- `req0_valid` / `req1_valid` input 1: request present.
- `req0_ready` / `req1_ready` output 1: request accepted this cycle.
- `req0_a`, `req0_b` / `req1_a`, `req1_b` input W: operands A and B.
- `req0_op` / `req1_op` input 4: ALU control code.
- `rsp0_valid` / `rsp1_valid` output 1: response present.
- `rsp0_ready` / `rsp1_ready` input 1: requester takes response.
- `rsp0_data` / `rsp1_data` output W: ALU result.
- `rsp0_zero` / `rsp1_zero` output 1: result == 0.
- `rsp0_err` / `rsp1_err` output 1: op code was illegal.
- `alu_busa`, `alu_busb` output W: to ALU BusA/BusB.
- `alu_ctrl` output 4: to ALU ALUCtrl.
- `alu_busw` input W: from ALU BusW.
- `alu_zero` input 1: from ALU Zero.

## Operation
- Legal ops: AND 0000, OR 0001, ADD 0010, SUB 0110, PassB 0111. All other codes are illegal.
- FSM states:
  - IDLE: arbitrate.
  - EXEC: ALU inputs stable; capture result at end of cycle.
  - RESP: hold response.
- IDLE behaviour:
  - If any req_valid, grant one requester and assert only its req_ready combinationally.
  - On the same edge, latch a/b/op into operand registers, record the grant owner, and go to EXEC.
  - With no valid request, stay in IDLE.
- Arbitration is round-robin on a 1-bit last-grant pointer.
  - Both valid: grant the port not granted last.
  - One valid: grant it regardless of the pointer.
  - The pointer updates only on a grant.
  - After reset the pointer gives priority to port 0.
- EXEC behaviour:
  - Legal op: result register <= alu_busw, zero <= alu_zero, err <= 0.
  - Illegal op: result <= 0, zero <= 1, err <= 1, ignoring ALU outputs.
  - Always go to RESP.
- RESP behaviour:
  - Only the owner's rsp_valid is high, with data/zero/err stable.
  - On owner rsp_valid && rsp_ready, go to IDLE.
  - Non-owner rsp_valid stays 0.
- alu_busa/alu_busb/alu_ctrl are driven only from the operand registers and keep their value outside EXEC. The ALU is never driven combinationally from request ports.
- Requester valid must not depend on ready. Operands must be held stable while valid is high and unaccepted.

## Timing
- Reset values:
  - FSM = IDLE, pointer selects port 0.
  - All req_ready, rsp_valid, rsp_data, rsp_zero and rsp_err = 0.
  - alu_busa = alu_busb = 0, alu_ctrl = 0000.
- Reset takes priority over every transition, including mid-EXEC or mid-RESP. Any in-flight response is discarded without a handshake.
- Latency: request accepted at edge N → rsp_valid high from cycle N+2 (after the edges ending IDLE and EXEC).
- Minimum spacing between grants is 3 cycles: IDLE, EXEC, RESP with immediate rsp_ready.
- A new request is not accepted in the cycle its predecessor's response handshakes. Acceptance resumes the following cycle in IDLE.
- Response backpressure holds the FSM in RESP indefinitely. Both req_ready signals stay 0 for the whole hold.
- Arithmetic is W-bit modulo, performed by the ALU. The block adds no carry or overflow output.

## Structure
- Shared package `alu_pkg`:
  - ALU op code constants (AND/OR/ADD/SUB/PassB).
  - FSM state encoding.
  - An `op_is_legal` function.
- One optional sub-module: `rr_arb2`, the 2-way round-robin grant logic with its pointer.
- The ALU itself is instantiated outside this block, at the datapath level.

## Test plan
- Single request, port 0 ADD a=5, b=7:
  - req0_ready pulses once.
  - alu_ctrl=0010 in EXEC.
  - rsp0_valid at N+2 with data=12, zero=0, err=0.
  - rsp1_valid stays 0.
- Simultaneous requests, both ports held valid, port0 SUB 9−9 and port1 OR 0xF0|0x0F:
  - Port 0 is granted first: data=0, zero=1.
  - Port 1 is granted next: data=0xFF, zero=0.
  - With both ports kept valid for four requests, the grant sequence is 0,1,0,1.
- Backpressure: rsp1_ready held low 5 cycles after rsp1_valid.
  - rsp1_data stays stable throughout.
  - req0_ready stays 0 while req0_valid is high.
  - Port 0 is granted the cycle after the handshake.
- Illegal op 1111 on port 1 with a=3, b=4:
  - rsp1_data=0, rsp1_zero=1, rsp1_err=1.
- SUB wrap-around, a=0, b=1:
  - data=0xFFFF_FFFF_FFFF_FFFF, zero=0.
- Reset asserted during EXEC and again during RESP:
  - The next cycle all outputs are at their reset values and the FSM is in IDLE.
  - A subsequent dual request grants port 0 first.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, arbiter FSM encoding and op legality check.
package alu_pkg;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB};
    endfunction
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant with a one-bit last-grant pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    // last_q holds the port granted most recently; resetting it to 1 favours port 0
    logic last_q;

    assign gnt_o = !en_i ? 2'b00 : (&req_i) ? (last_q ? 2'b01 : 2'b10) : req_i;

    always_ff @(posedge clk) begin
        if (rst)
            last_q <= 1'b1;
        else if (|gnt_o)
            last_q <= gnt_o[1];
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two valid/ready requesters
// and returns the captured result on the granted requester's response channel.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         CLK,
    input  logic         Reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [3:0]   req0_op,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [3:0]   req1_op,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [W-1:0] rsp0_data,
    output logic         rsp0_zero,
    output logic         rsp0_err,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [W-1:0] rsp1_data,
    output logic         rsp1_zero,
    output logic         rsp1_err,
    output logic [W-1:0] alu_busa,
    output logic [W-1:0] alu_busb,
    output logic [3:0]   alu_ctrl,
    input  logic [W-1:0] alu_busw,
    input  logic         alu_zero
);
    state_e       state_q, state_d;
    logic         owner_q, owner_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [3:0]   op_q, op_d;
    logic         zero_q, zero_d, err_q, err_d;
    logic [1:0]   gnt;
    logic         legal;

    rr_arb2 u_arb (
        .clk  (CLK),
        .rst  (Reset),
        .en_i (state_q == ST_IDLE),
        .req_i({req1_valid, req0_valid}),
        .gnt_o(gnt)
    );

    assign legal      = op_is_legal(op_q);
    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign rsp0_valid = (state_q == ST_RESP) && !owner_q;
    assign rsp1_valid = (state_q == ST_RESP) && owner_q;
    assign rsp0_data  = res_q;
    assign rsp1_data  = res_q;
    assign rsp0_zero  = zero_q;
    assign rsp1_zero  = zero_q;
    assign rsp0_err   = err_q;
    assign rsp1_err   = err_q;
    // ALU is fed only from the operand registers, never from the request ports
    assign alu_busa   = a_q;
    assign alu_busb   = b_q;
    assign alu_ctrl   = op_q;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (|gnt) begin
                state_d = ST_EXEC;
                owner_d = gnt[1];
                a_d     = gnt[1] ? req1_a : req0_a;
                b_d     = gnt[1] ? req1_b : req0_b;
                op_d    = gnt[1] ? req1_op : req0_op;
            end
            ST_EXEC: begin
                state_d = ST_RESP;
                res_d   = legal ? alu_busw : '0;
                zero_d  = legal ? alu_zero : 1'b1;
                err_d   = !legal;
            end
            ST_RESP: if (owner_q ? rsp1_ready : rsp0_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            res_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end
endmodule
